// File: rtl/ac_ctrl.sv
// Command sequencer for an accumulator datapath: decodes one command at a time
// into registered, mutually exclusive accumulator strobes, with abort and completion status.
module ac_ctrl (
   input  logic       clk,
   input  logic       rstn,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_cnt,
   input  logic       abort,
   input  logic       zflag,
   output logic       cmd_ready,
   output logic       writealu,
   output logic       writebus,
   output logic       rstac,
   output logic       incac,
   output logic       read,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       z_status,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CLR  = 3'd1,
      LOAD = 3'd2,
      INC  = 3'd3,
      RD   = 3'd4,
      DONE = 3'd5
   } state_e;

   localparam logic [2:0] OP_NOP       = 3'd0;
   localparam logic [2:0] OP_CLR       = 3'd1;
   localparam logic [2:0] OP_LD_BUS    = 3'd2;
   localparam logic [2:0] OP_LD_ALU    = 3'd3;
   localparam logic [2:0] OP_INC_N     = 3'd4;
   localparam logic [2:0] OP_RD        = 3'd5;
   localparam logic [2:0] OP_CLR_INC_N = 3'd6;
   localparam logic [2:0] OP_LD_BUS_RD = 3'd7;

   state_e     state;
   logic [2:0] op_q;
   logic [7:0] cnt_q;

   assign state_dbg = state;

   // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
   // cmd_ready is high only in IDLE, so commands offered while busy are dropped, not queued.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         op_q      <= OP_NOP;
         cnt_q     <= 8'd0;
         cmd_ready <= 1'b1;
         writealu  <= 1'b0;
         writebus  <= 1'b0;
         rstac     <= 1'b0;
         incac     <= 1'b0;
         read      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
         z_status  <= 1'b0;
      end else begin
         writealu <= 1'b0;
         writebus <= 1'b0;
         rstac    <= 1'b0;
         incac    <= 1'b0;
         read     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;

         if (abort && (state inside {CLR, LOAD, INC, RD})) begin
            state     <= IDLE;
            cnt_q     <= 8'd0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            aborted   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (cmd_valid) begin
                     op_q      <= cmd_op;
                     cnt_q     <= cmd_cnt;
                     busy      <= 1'b1;
                     cmd_ready <= 1'b0;
                     case (cmd_op)
                        OP_NOP: begin
                           state <= DONE;
                           done  <= 1'b1;
                        end
                        OP_CLR, OP_CLR_INC_N: begin
                           state <= CLR;
                           rstac <= 1'b1;
                        end
                        OP_LD_BUS, OP_LD_BUS_RD: begin
                           state    <= LOAD;
                           writebus <= 1'b1;
                        end
                        OP_LD_ALU: begin
                           state    <= LOAD;
                           writealu <= 1'b1;
                        end
                        OP_INC_N: begin
                           if (cmd_cnt == 8'd0) begin
                              state <= DONE;
                              done  <= 1'b1;
                           end else begin
                              state <= INC;
                              incac <= 1'b1;
                           end
                        end
                        OP_RD: begin
                           state <= RD;
                           read  <= 1'b1;
                        end
                     endcase
                  end
               end
               CLR: begin
                  if (op_q == OP_CLR_INC_N && cnt_q != 8'd0) begin
                     state <= INC;
                     incac <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
               LOAD: begin
                  if (op_q == OP_LD_BUS_RD) begin
                     state <= RD;
                     read  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
               // cnt_q counts the incac cycles still owed, including the current one.
               INC: begin
                  cnt_q <= cnt_q - 8'd1;
                  if (cnt_q <= 8'd1) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     incac <= 1'b1;
                  end
               end
               RD: begin
                  state <= DONE;
                  done  <= 1'b1;
               end
               DONE: begin
                  state     <= IDLE;
                  cnt_q     <= 8'd0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  z_status  <= zflag;
               end
               default: begin
                  state     <= IDLE;
                  cnt_q     <= 8'd0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ac_ctrl.sv
// Randomised scoreboard bench for ac_ctrl with a small accumulator environment
// and a command-level reference model of strobe sequences and accumulator value.
module tb_ac_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [7:0]  cmd_cnt;
   logic        abort;
   logic        zflag;
   logic        cmd_ready, writealu, writebus, rstac, incac, read;
   logic        busy, done, aborted, z_status;
   logic [2:0]  state_dbg;

   logic [15:0] acc, rd_data, bus_data, alu_data;

   localparam logic [4:0] ST_WA  = 5'b10000;
   localparam logic [4:0] ST_WB  = 5'b01000;
   localparam logic [4:0] ST_RST = 5'b00100;
   localparam logic [4:0] ST_INC = 5'b00010;
   localparam logic [4:0] ST_RD  = 5'b00001;

   // expected word: {z_status, writealu, writebus, rstac, incac, read, done, aborted, busy}
   logic [8:0]  exp_q[$];
   logic [15:0] model_acc;
   logic        model_z;

   int n_checks = 0;
   int n_pass = 0;
   int n_accepted = 0;
   int n_aborted = 0;
   int n_rst_cancel = 0;
   int done_seen = 0;
   int aborted_seen = 0;

   ac_ctrl dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
      .abort(abort), .zflag(zflag), .cmd_ready(cmd_ready), .writealu(writealu),
      .writebus(writebus), .rstac(rstac), .incac(incac), .read(read), .busy(busy),
      .done(done), .aborted(aborted), .z_status(z_status), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   // accumulator datapath driven by the controller strobes
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc     <= 16'd0;
         rd_data <= 16'd0;
      end else begin
         if (rstac) acc <= 16'd0;
         else if (writebus) acc <= bus_data;
         else if (writealu) acc <= alu_data;
         else if (incac) acc <= acc + 16'd1;
         if (read) rd_data <= acc;
      end
   end
   assign zflag = (acc == 16'd0);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   // monitor: pops one expected word for every cycle the DUT shows activity
   always @(negedge clk) begin
      logic [8:0] got;
      if (rstn) begin
         got = {z_status, writealu, writebus, rstac, incac, read, done, aborted, busy};
         check("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
         check("strobe_onehot", 32'($countones(got[7:3]) <= 1), 32'd1);
         if (done) done_seen++;
         if (aborted) aborted_seen++;
         if (busy || aborted || done || (|got[7:3])) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_output: got %h, expected no activity at %0t", got, $time);
            end else begin
               check("seq_word", 32'(got), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] cnt, input int k_abort,
                          input int rst_at, input logic [15:0] bus, input logic [15:0] alu);
      logic [4:0]  strb[$];
      logic [15:0] a;
      logic [15:0] exp_rd;
      logic        has_rd;
      int          g, ns, nbusy;
      g = 0;
      while (!cmd_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      check("ready_before_cmd", 32'(cmd_ready), 32'd1);
      if (!cmd_ready) return;
      bus_data  = bus;
      alu_data  = alu;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_cnt   = cnt;
      abort     = 1'($urandom_range(0, 1));
      case (op)
         3'd1: strb.push_back(ST_RST);
         3'd2: strb.push_back(ST_WB);
         3'd3: strb.push_back(ST_WA);
         3'd4: for (int i = 0; i < int'(cnt); i++) strb.push_back(ST_INC);
         3'd5: strb.push_back(ST_RD);
         3'd6: begin
            strb.push_back(ST_RST);
            for (int i = 0; i < int'(cnt); i++) strb.push_back(ST_INC);
         end
         3'd7: begin
            strb.push_back(ST_WB);
            strb.push_back(ST_RD);
         end
         default: ;
      endcase
      ns = strb.size();
      if (k_abort > ns) k_abort = 0;
      a = model_acc;
      has_rd = 1'b0;
      exp_rd = 16'd0;
      for (int i = 0; i < ((k_abort != 0) ? k_abort : ns); i++) begin
         exp_q.push_back({model_z, strb[i], 3'b001});
         case (strb[i])
            ST_RST: a = 16'd0;
            ST_WB:  a = bus;
            ST_WA:  a = alu;
            ST_INC: a = a + 16'd1;
            default: begin
               has_rd = 1'b1;
               exp_rd = a;
            end
         endcase
      end
      if (k_abort != 0) begin
         exp_q.push_back({model_z, 5'b0, 3'b010});
         nbusy = k_abort;
         n_aborted++;
      end else begin
         exp_q.push_back({model_z, 5'b0, 3'b101});
         nbusy = ns + 1;
      end
      n_accepted++;
      for (int c = 1; c <= nbusy; c++) begin
         @(negedge clk);
         if (c == rst_at) begin
            #2 rstn = 1'b0;
            #1;
            check("rst_async", 32'({busy, done, aborted, z_status, writealu, writebus,
                  rstac, incac, read, cmd_ready}), 32'b0000000001);
            exp_q.delete();
            model_acc = 16'd0;
            model_z = 1'b0;
            n_rst_cancel++;
            cmd_valid = 1'b0;
            abort = 1'b0;
            #1 rstn = 1'b1;
            return;
         end
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_op    = 3'($urandom_range(0, 7));
         cmd_cnt   = 8'($urandom_range(0, 255));
         abort     = (c == k_abort) || (k_abort == 0 && c == nbusy && $urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      abort = 1'b0;
      check("ready_after_cmd", 32'(cmd_ready), 32'd1);
      model_acc = a;
      if (k_abort == 0) model_z = (a == 16'd0);
      if (has_rd) check("read_data", 32'(rd_data), 32'(exp_rd));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [2:0] op;
      logic [7:0] cnt;
      int         k;
      cmd_valid = 1'b0;
      cmd_op = 3'd0;
      cmd_cnt = 8'd0;
      abort = 1'b0;
      bus_data = 16'd0;
      alu_data = 16'd0;
      model_acc = 16'd0;
      model_z = 1'b0;
      #2 rstn = 1'b0;
      #1;
      check("reset_values", 32'({busy, done, aborted, z_status, writealu, writebus,
            rstac, incac, read, cmd_ready}), 32'b0000000001);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b1;

      run_cmd(3'd1, 8'd0, 0, 0, 16'h1234, 16'h0);
      run_cmd(3'd4, 8'd3, 0, 0, 16'h0, 16'h0);
      run_cmd(3'd7, 8'd0, 0, 0, 16'h00A5, 16'h0);
      run_cmd(3'd4, 8'd0, 0, 0, 16'h0, 16'h0);
      run_cmd(3'd6, 8'd0, 0, 0, 16'h0, 16'h0);
      run_cmd(3'd4, 8'd200, 10, 0, 16'h0, 16'h0);
      run_cmd(3'd0, 8'd9, 0, 0, 16'h0, 16'h0);
      run_cmd(3'd3, 8'd0, 0, 0, 16'h0, 16'h5A5A);
      run_cmd(3'd5, 8'd0, 0, 0, 16'h0, 16'h0);
      run_cmd(3'd6, 8'd4, 1, 0, 16'h0, 16'h0);
      run_cmd(3'd7, 8'd0, 2, 0, 16'h0042, 16'h0);
      run_cmd(3'd4, 8'd50, 0, 5, 16'h0, 16'h0);
      run_cmd(3'd1, 8'd0, 0, 0, 16'h0, 16'h0);

      for (int n = 0; n < 150; n++) begin
         op  = 3'($urandom_range(0, 7));
         cnt = 8'($urandom_range(0, 5));
         k   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
         run_cmd(op, cnt, k, 0,
                 ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom));
      end

      cmd_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_z_status", 32'(z_status), 32'(model_z));
      check("done_count", 32'(done_seen), 32'(n_accepted - n_aborted - n_rst_cancel));
      check("aborted_count", 32'(aborted_seen), 32'(n_aborted));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
